// File: rtl/tone_player_if.sv
// Note command channel for tone_player: valid/ready handshake carrying tone, octave and duration.
// The source holds every field stable while note_valid is high and note_ready is low.
interface tone_player_if #(
  parameter int DUR_W = 10
) ();
  logic             note_valid;
  logic             note_ready;
  logic [3:0]       note_tone;
  logic [1:0]       note_oct;
  logic [DUR_W-1:0] note_dur;

  modport master (
    output note_valid,
    output note_tone,
    output note_oct,
    output note_dur,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_tone,
    input  note_oct,
    input  note_dur,
    output note_ready
  );
endinterface

// File: rtl/tone_player.sv
// Square-wave note player: one-entry command slot, PLAY for dur ticks, silent GAP, then a done pulse.
// PLAY starts one cycle after accept when idle; a full slot holds note_ready low until the next pop.
module tone_player #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1000,
  parameter int DUR_W     = 10,
  parameter int GAP_TICKS = 10,
  parameter int HP_W      = 24
) (
  input  logic         sys_clk,
  input  logic         reset,
  tone_player_if.slave note_if,
  input  logic         stop,
  output logic         busy,
  output logic         done,
  output logic         Out
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int CNT_W    = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [TK_W-1:0]  TICK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  // Octave-4 half periods in clock cycles; all divisions fold to constants.
  function automatic logic [HP_W-1:0] hp_base(input logic [3:0] t);
    case (t)
      4'd0:    hp_base = HP_W'(CLK_HZ / (2 * 261));
      4'd1:    hp_base = HP_W'(CLK_HZ / (2 * 277));
      4'd2:    hp_base = HP_W'(CLK_HZ / (2 * 293));
      4'd3:    hp_base = HP_W'(CLK_HZ / (2 * 311));
      4'd4:    hp_base = HP_W'(CLK_HZ / (2 * 329));
      4'd5:    hp_base = HP_W'(CLK_HZ / (2 * 349));
      4'd6:    hp_base = HP_W'(CLK_HZ / (2 * 370));
      4'd7:    hp_base = HP_W'(CLK_HZ / (2 * 392));
      4'd8:    hp_base = HP_W'(CLK_HZ / (2 * 415));
      4'd9:    hp_base = HP_W'(CLK_HZ / (2 * 440));
      4'd10:   hp_base = HP_W'(CLK_HZ / (2 * 466));
      4'd11:   hp_base = HP_W'(CLK_HZ / (2 * 494));
      default: hp_base = '0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             slot_full_q, slot_full_d;
  logic [3:0]       slot_tone_q, slot_tone_d;
  logic [1:0]       slot_oct_q, slot_oct_d;
  logic [DUR_W-1:0] slot_dur_q, slot_dur_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
  logic [TK_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rest_q, rest_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             start;
  logic             finish;
  logic             tick_wrap;
  logic [HP_W-1:0]  base_hp;
  logic [HP_W-1:0]  slot_hp;

  always_comb begin
    base_hp = hp_base(slot_tone_q);
    case (slot_oct_q)
      2'd0:    slot_hp = base_hp << 1;
      2'd1:    slot_hp = base_hp;
      2'd2:    slot_hp = base_hp >> 1;
      default: slot_hp = base_hp >> 2;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_tone_d = slot_tone_q;
    slot_oct_d  = slot_oct_q;
    slot_dur_d  = slot_dur_q;
    hp_d        = hp_q;
    hp_cnt_d    = hp_cnt_q;
    tick_d      = tick_q;
    cnt_d       = cnt_q;
    rest_d      = rest_q;
    out_d       = out_q;
    done_d      = 1'b0;
    start       = 1'b0;
    finish      = 1'b0;
    accept      = note_if.note_valid & ready_q & ~stop;
    tick_wrap   = (tick_q == TICK_LAST);

    case (state_q)
      IDLE: begin
        if (slot_full_q) start = 1'b1;
      end
      PLAY: begin
        if (cnt_q == '0) begin
          // Zero-length note: report completion immediately, no gap.
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          tick_d = tick_wrap ? '0 : tick_q + 1'b1;
          if (hp_cnt_q == '0) begin
            hp_cnt_d = hp_q - 1'b1;
            if (!rest_q) out_d = ~out_q;
          end else begin
            hp_cnt_d = hp_cnt_q - 1'b1;
          end
          if (tick_wrap) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) begin
              out_d = 1'b0;
              if (GAP_TICKS == 0) begin
                finish = 1'b1;
              end else begin
                state_d = GAP;
                cnt_d   = GAP_LOAD;
              end
            end
          end
        end
      end
      GAP: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) finish = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished note chains straight into the pending one, avoiding an IDLE bubble.
    if (finish) begin
      done_d = 1'b1;
      if (slot_full_q) start = 1'b1;
      else state_d = IDLE;
    end

    if (start) begin
      state_d  = PLAY;
      hp_d     = slot_hp;
      hp_cnt_d = slot_hp - 1'b1;
      tick_d   = '0;
      cnt_d    = CNT_W'(slot_dur_q);
      rest_d   = (slot_tone_q >= 4'd12);
      out_d    = 1'b0;
    end

    if (start) slot_full_d = 1'b0;
    if (accept) begin
      slot_full_d = 1'b1;
      slot_tone_d = note_if.note_tone;
      slot_oct_d  = note_if.note_oct;
      slot_dur_d  = note_if.note_dur;
    end

    if (stop) begin
      state_d     = IDLE;
      slot_full_d = 1'b0;
      out_d       = 1'b0;
      done_d      = 1'b0;
      hp_cnt_d    = '0;
      tick_d      = '0;
      cnt_d       = '0;
    end

    ready_d = ~slot_full_d & ~stop;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      slot_full_q <= 1'b0;
      slot_tone_q <= '0;
      slot_oct_q  <= '0;
      slot_dur_q  <= '0;
      hp_q        <= '0;
      hp_cnt_q    <= '0;
      tick_q      <= '0;
      cnt_q       <= '0;
      rest_q      <= 1'b0;
      out_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot_tone_q <= slot_tone_d;
      slot_oct_q  <= slot_oct_d;
      slot_dur_q  <= slot_dur_d;
      hp_q        <= hp_d;
      hp_cnt_q    <= hp_cnt_d;
      tick_q      <= tick_d;
      cnt_q       <= cnt_d;
      rest_q      <= rest_d;
      out_q       <= out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign note_if.note_ready = ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign Out                = out_q;

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player: stimulus queues expected Out edges and done pulses by cycle,
// a negedge monitor pops and compares every edge/pulse the DUT produces.
module tb_tone_player;
  localparam int GAP_CYC = 2000;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  logic stop    = 1'b0;
  logic busy, done, Out;
  logic prev_out = 1'b0;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  tone_player_if #(.DUR_W(10)) nif ();

  tone_player #(
    .CLK_HZ   (1000000),
    .TICK_HZ  (1000),
    .DUR_W    (10),
    .GAP_TICKS(2),
    .HP_W     (24)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .note_if(nif),
    .stop   (stop),
    .busy   (busy),
    .done   (done),
    .Out    (Out)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: every Out edge and done pulse must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (Out !== prev_out) begin
      check_ev(Out ? EV_RISE : EV_FALL);
      prev_out = Out;
    end
    if (done === 1'b1) check_ev(EV_DONE);
  end

  // p = cycle of PLAY entry, hp = half period, d = audible cycles.
  task automatic expect_note(input int p, input int hp, input int d, input bit rest);
    bit lvl;
    lvl = 1'b0;
    if (d == 0) begin
      push(EV_DONE, p + 1);
    end else begin
      if (!rest) begin
        for (int t = hp; t < d; t += hp) begin
          lvl = ~lvl;
          push(lvl ? EV_RISE : EV_FALL, p + t);
        end
      end
      if (lvl) push(EV_FALL, p + d);
      push(EV_DONE, p + d + GAP_CYC);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  // Called at a negedge; returns the index of the accepting clock edge, leaves caller at that negedge.
  task automatic send(input int tone, input int oct, input int dur, output int acc);
    int guard;
    guard = 0;
    nif.note_valid = 1'b1;
    nif.note_tone  = 4'(tone);
    nif.note_oct   = 2'(oct);
    nif.note_dur   = 10'(dur);
    while (nif.note_ready !== 1'b1 && guard < 20000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: note_ready stayed 0 for %0d cycles, required 1", guard);
    end
    acc = cyc + 1;
    @(negedge sys_clk);
    nif.note_valid = 1'b0;
  endtask

  initial begin
    int acc, acc2, p, p0, p1, p2, p3;
    nif.note_valid = 1'b0;
    nif.note_tone  = '0;
    nif.note_oct   = '0;
    nif.note_dur   = '0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_out", int'(Out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(nif.note_ready), 1);
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);

    // A4, 5 ticks: toggles every 1136 cycles, gap, done; busy over PLAY+GAP
    send(9, 1, 5, acc);
    p = acc + 1;
    expect_note(p, 1136, 5000, 1'b0);
    chk("a4_ready_after_accept", int'(nif.note_ready), 0);
    chk("a4_busy_before_play", int'(busy), 0);
    wait_cyc(p);
    chk("a4_busy_play", int'(busy), 1);
    chk("a4_ready_after_pop", int'(nif.note_ready), 1);
    wait_cyc(p + 6999);
    chk("a4_busy_gap_end", int'(busy), 1);
    wait_cyc(p + 7000);
    chk("a4_busy_idle", int'(busy), 0);
    @(negedge sys_clk);

    // C in four octaves, chained: half periods 3830/1915/957/478
    send(0, 0, 4, acc);
    p0 = acc + 1;
    expect_note(p0, 3830, 4000, 1'b0);
    send(0, 1, 4, acc);
    chk("oct1_accept", acc, p0 + 1);
    p1 = p0 + 6000;
    expect_note(p1, 1915, 4000, 1'b0);
    send(0, 2, 4, acc);
    chk("oct2_accept", acc, p1 + 1);
    p2 = p1 + 6000;
    expect_note(p2, 957, 4000, 1'b0);
    send(0, 3, 4, acc);
    chk("oct3_accept", acc, p2 + 1);
    p3 = p2 + 6000;
    expect_note(p3, 478, 4000, 1'b0);
    wait_cyc(p3 + 6002);

    // Back-to-back E4 / G4, 3 ticks each
    send(4, 1, 3, acc);
    chk("b2b_ready_full", int'(nif.note_ready), 0);
    p1 = acc + 1;
    expect_note(p1, 1519, 3000, 1'b0);
    send(7, 1, 3, acc2);
    chk("b2b_second_accept", acc2, p1 + 1);
    chk("b2b_ready_pending", int'(nif.note_ready), 0);
    expect_note(p1 + 5000, 1275, 3000, 1'b0);
    wait_cyc(p1 + 4999);
    chk("b2b_ready_before_pop", int'(nif.note_ready), 0);
    wait_cyc(p1 + 5000);
    chk("b2b_no_idle_bubble", int'(busy), 1);
    chk("b2b_ready_after_pop", int'(nif.note_ready), 1);
    wait_cyc(p1 + 10002);

    // Rest for 4 ticks, then a zero-length note queued behind it
    send(15, 1, 4, acc);
    p = acc + 1;
    expect_note(p, 0, 4000, 1'b1);
    send(0, 1, 0, acc);
    expect_note(p + 6000, 0, 0, 1'b0);
    wait_cyc(p + 6000);
    chk("dur0_busy_play", int'(busy), 1);
    wait_cyc(p + 6001);
    chk("dur0_busy_idle", int'(busy), 0);
    wait_cyc(p + 6004);

    // stop mid-PLAY with a pending note and a same-cycle command
    send(9, 1, 5, acc);
    p = acc + 1;
    push(EV_RISE, p + 1136);
    push(EV_FALL, p + 1500);
    send(0, 1, 2, acc);
    chk("stop_pending_accept", acc, p + 1);
    wait_cyc(p + 1499);
    chk("stop_out_high", int'(Out), 1);
    stop = 1'b1;
    nif.note_valid = 1'b1;
    nif.note_tone  = 4'd2;
    nif.note_oct   = 2'd1;
    nif.note_dur   = 10'd1;
    @(negedge sys_clk);
    chk("stop_out", int'(Out), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_ready_held", int'(nif.note_ready), 0);
    stop = 1'b0;
    nif.note_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("stop_slot_empty", int'(busy), 0);
    chk("stop_ready_back", int'(nif.note_ready), 1);
    // Idle with ready=1: stop must win over the simultaneous accept
    stop = 1'b1;
    nif.note_valid = 1'b1;
    @(negedge sys_clk);
    chk("stop_idle_ready", int'(nif.note_ready), 0);
    stop = 1'b0;
    nif.note_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("stop_cmd_dropped", int'(busy), 0);

    // Asynchronous reset while Out is high
    send(9, 1, 5, acc);
    p = acc + 1;
    push(EV_RISE, p + 1136);
    wait_cyc(p + 1200);
    chk("rst_mid_out_high", int'(Out), 1);
    push(EV_FALL, cyc + 1);
    #2 reset = 1'b0;
    #1 chk("rst_mid_out_async", int'(Out), 0);
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("rst_mid_ready", int'(nif.note_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (5) @(negedge sys_clk);
    chk("rst_mid_still_idle", int'(busy), 0);

    repeat (10) @(negedge sys_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
